aes256_dec_round_sequencer: RTL and testbench
=============================================

Name: aes256_dec_round_sequencer

Overview:
Iterative controller for AES-256 decryption around one shared, external, combinational inverse-round unit (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). It stores the 15 expanded round keys, accepts ciphertext blocks over a valid/ready handshake, and performs the initial AddRoundKey. It then steps the round unit through NR iterations and returns plaintext over a valid/ready handshake. This replaces the fully unrolled decrypt pipeline where area matters more than throughput.

Parameters:
NR, 14, number of rounds; legal values 10/12/14; uses key slots 0..NR.
DW, 128, block and round-key width; fixed at 128.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
key_wr_en  in  1  round-key write strobe
key_wr_idx  in  4  slot index 0..NR, encryption numbering (0 = cipher key upper half)
key_wr_data  in  DW  round-key value
key_wr_err  out  1  one-cycle pulse: write dropped (busy or idx > NR)
keys_ready  out  1  all slots 0..NR written since reset
in_valid  in  1  ciphertext valid
in_ready  out  1  ciphertext accepted when valid && ready
in_data  in  DW  ciphertext
out_valid  out  1  plaintext valid
out_ready  in  1  downstream ready
out_data  out  DW  plaintext
rnd_state  out  DW  state fed to round unit (registered)
rnd_key  out  DW  round key fed to round unit
rnd_last  out  1  final round: round unit bypasses InvMixColumns
rnd_result  in  DW  combinational round-unit result
busy  out  1  FSM not in IDLE
round_cnt  out  4  current round 1..NR, 0 when idle

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; slot-written bitmap cleared; state register = 0. Outputs: in_ready=0, out_valid=0, out_data=0, key_wr_err=0, keys_ready=0, busy=0, round_cnt=0, rnd_last=0. Key storage contents are don't-care. Deassertion takes effect at the next clk edge.
- Key writes: accepted only in IDLE with idx <= NR. Each accepted write stores data and sets its bitmap bit. Otherwise the write is dropped and key_wr_err=1 for the next cycle. A rewrite of a valid slot overwrites it. keys_ready = AND of bitmap bits 0..NR.
- in_ready = (FSM==IDLE) && keys_ready && !key_wr_en. A key write and block acceptance never coincide; the key write wins.
- IDLE: on accept, state <= in_data ^ key[NR]; round_cnt <= 1; go ROUND.
- ROUND: rnd_state = state register; rnd_key = key[NR - round_cnt]; rnd_last = (round_cnt==NR). Each cycle, state <= rnd_result.
  - round_cnt < NR: increment round_cnt.
  - round_cnt == NR: out_data <= rnd_result; out_valid <= 1; go DONE.
- DONE: hold out_data and out_valid until out_ready. On out_valid && out_ready: out_valid <= 0; round_cnt <= 0; go IDLE. No same-cycle re-accept; in_ready rises the cycle after the handshake.
- Latency: accept at edge T; out_valid high after edge T+NR (14 cycles for NR=14). Throughput: one block per NR+2 cycles with out_ready held high.
- out_data remains stable while out_valid=1 and out_ready=0.
- busy = (FSM != IDLE). In IDLE: rnd_last=0 and rnd_key=key[0]; the round unit result is ignored.
- Reset mid-operation: the block in flight is discarded. Keys must be reloaded because the bitmap is cleared.
- No illegal FSM states reachable. Unused encodings return to IDLE.

Test Plan:
- FIPS-197 C.3 AES-256 vectors, NR=14: load slots 0..14 from the expanded key of 000102..1f, then send ciphertext 8ea2b7ca516745bfeafc49904b496089 -> out_data=00112233445566778899aabbccddeeff, out_valid exactly 14 cycles after accept.
- Slots 0..13 written only: keys_ready=0 and in_ready=0 with in_valid held high. Write slot 14 -> in_ready=1 next cycle.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0. Raise out_ready -> in_ready=1 the cycle after; back-to-back second block also decrypts correctly.
- key_wr_en during ROUND (idx=3) -> key_wr_err pulses 1 cycle; the current block result is unchanged; slot 3 is unchanged on a later block.
- key_wr_idx=15 in IDLE -> key_wr_err=1, keys_ready unchanged.
- rst_n low at round 7 -> outputs immediately at reset values. After release, keys_ready=0; reload keys and repeat the vector -> correct plaintext.

Source files
------------

// File: rtl/aes256_dec_round_sequencer.sv
// Iterative AES-256 decryption sequencer: stores the round-key schedule and steps one
// external combinational inverse-round unit through NR rounds per ciphertext block.
module aes256_dec_round_sequencer #(
    parameter int NR = 14,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_wr_en,
    input  logic [3:0]    key_wr_idx,
    input  logic [DW-1:0] key_wr_data,
    output logic          key_wr_err,
    output logic          keys_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] rnd_state,
    output logic [DW-1:0] rnd_key,
    output logic          rnd_last,
    input  logic [DW-1:0] rnd_result,
    output logic          busy,
    output logic [3:0]    round_cnt
);
    // Handshakes: a beat transfers on a rising edge where valid && ready; the side
    // holding valid keeps its data stable until that edge.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} fsm_t;
    localparam logic [3:0] LAST = 4'(NR);

    fsm_t          fsm_q, fsm_d;
    logic [DW-1:0] blk_q, blk_d;
    logic [DW-1:0] out_q, out_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ov_q, ov_d;
    logic [NR:0]   slot_q;
    logic          err_q;
    logic [DW-1:0] key_mem [0:NR];
    logic          idle, key_ok, accept;
    logic [3:0]    key_sel;

    assign idle       = (fsm_q == S_IDLE);
    assign key_ok     = key_wr_en && idle && (key_wr_idx <= LAST);
    assign keys_ready = &slot_q;
    assign in_ready   = idle && keys_ready && !key_wr_en;
    assign accept     = in_valid && in_ready;

    // Decryption walks the encryption-numbered schedule backwards.
    assign key_sel    = (fsm_q == S_ROUND) ? (LAST - cnt_q) : 4'd0;
    assign rnd_state  = blk_q;
    assign rnd_key    = key_mem[key_sel];
    assign rnd_last   = (fsm_q == S_ROUND) && (cnt_q == LAST);
    assign busy       = !idle;
    assign round_cnt  = cnt_q;
    assign out_valid  = ov_q;
    assign out_data   = out_q;
    assign key_wr_err = err_q;

    always_ff @(posedge clk) begin
        if (key_ok) key_mem[key_wr_idx] <= key_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            blk_q  <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            slot_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            err_q  <= key_wr_en && !key_ok;
            if (key_ok) slot_q[key_wr_idx] <= 1'b1;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        blk_d = blk_q;
        out_d = out_q;
        cnt_d = cnt_q;
        ov_d  = ov_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    blk_d = in_data ^ key_mem[LAST];
                    cnt_d = 4'd1;
                    fsm_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = rnd_result;
                if (cnt_q == LAST) begin
                    out_d = rnd_result;
                    ov_d  = 1'b1;
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    cnt_d = 4'd0;
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                ov_d  = 1'b0;
                cnt_d = 4'd0;
                fsm_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_aes256_dec_round_sequencer.sv
// Bench for aes256_dec_round_sequencer: supplies a behavioural AES inverse-round unit and
// checks every cycle against a transaction-level model plus FIPS-197 AES-256 vectors.
module tb_aes256_dec_round_sequencer;
    localparam int NR = 14;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_IS1 = 128'haa5ece06ee6e3c56dde68bac2621bebf;
    localparam logic [127:0] FIPS_K14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;
    logic         key_wr_err, keys_ready;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data, rnd_state, rnd_key, rnd_result;
    logic         rnd_last, busy;
    logic [3:0]   round_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sbox [0:255];
    logic [7:0]   inv_sbox [0:255];
    logic [127:0] xk [0:14];
    logic [127:0] acc_state;

    // model state
    logic [127:0] exp_q [$];
    logic [127:0] m_keys [0:15];
    bit           m_written [0:15];
    logic [127:0] m_state;
    int           m_cnt;
    bit           m_done, m_err;

    aes256_dec_round_sequencer #(.NR(NR), .DW(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_wr_err(key_wr_err), .keys_ready(keys_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_last(rnd_last),
        .rnd_result(rnd_result), .busy(busy), .round_cnt(round_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] v, s;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            if (x != 0) begin
                v = 8'h01;
                for (int k = 0; k < 254; k++) v = gmul(v, 8'(x));
            end
            s = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
            sbox[x] = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] ck);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = ck[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) xk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                b[row + 4*((col + row) % 4)] = a[row + 4*col];
        for (int i = 0; i < 16; i++) b[i] = inv_sbox[b[i]] ^ k[127-8*i -: 8];
        if (!last) begin
            for (int col = 0; col < 4; col++) begin
                c0 = b[4*col]; c1 = b[4*col+1]; c2 = b[4*col+2]; c3 = b[4*col+3];
                b[4*col]   = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
                b[4*col+1] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
                b[4*col+2] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
                b[4*col+3] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ m_keys[NR];
        for (int r = 1; r <= NR; r++) s = inv_round(s, m_keys[NR - r], r == NR);
        return s;
    endfunction

    // external round unit
    always @(rnd_state, rnd_key, rnd_last) rnd_result = inv_round(rnd_state, rnd_key, rnd_last);

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 50) $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // per-cycle compare + model advance
    always @(negedge clk) begin
        bit m_all, m_idle, exp_rdy, err_n;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) m_written[i] = 1'b0;
            m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_state = '0;
        end else begin
            m_all = 1'b1;
            for (int i = 0; i <= NR; i++) m_all = m_all & m_written[i];
            m_idle  = (m_cnt == 0);
            exp_rdy = m_idle && m_all && !key_wr_en;
            chk("busy", 128'(busy), 128'(!m_idle));
            chk("round_cnt", 128'(round_cnt), 128'(m_cnt));
            chk("keys_ready", 128'(keys_ready), 128'(m_all));
            chk("in_ready", 128'(in_ready), 128'(exp_rdy));
            chk("key_wr_err", 128'(key_wr_err), 128'(m_err));
            chk("out_valid", 128'(out_valid), 128'(m_done));
            if (m_done && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
            if (!m_idle && !m_done) begin
                chk("rnd_last", 128'(rnd_last), 128'(m_cnt == NR));
                chk("rnd_key", rnd_key, m_keys[NR - m_cnt]);
                chk("rnd_state", rnd_state, m_state);
            end
            if (m_idle) begin
                chk("rnd_last_idle", 128'(rnd_last), 128'(0));
                if (m_written[0]) chk("rnd_key_idle", rnd_key, m_keys[0]);
            end
            err_n = key_wr_en && !(m_idle && key_wr_idx <= 4'(NR));
            if (key_wr_en && m_idle && key_wr_idx <= 4'(NR)) begin
                m_keys[key_wr_idx]    = key_wr_data;
                m_written[key_wr_idx] = 1'b1;
            end
            if (in_valid && exp_rdy) begin
                exp_q.push_back(ref_decrypt(in_data));
                m_state = in_data ^ m_keys[NR];
                m_cnt   = 1;
            end else if (!m_idle && !m_done) begin
                m_state = inv_round(m_state, m_keys[NR - m_cnt], m_cnt == NR);
                if (m_cnt == NR) m_done = 1'b1;
                else m_cnt++;
            end else if (m_done && out_ready) begin
                m_done = 1'b0;
                m_cnt  = 0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            m_err = err_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_key(input logic [3:0] idx, input logic [127:0] d);
        @(posedge clk); #2;
        key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = d;
        @(posedge clk); #2;
        key_wr_en = 1'b0;
    endtask

    task automatic load_fips_keys();
        for (int i = 0; i <= NR; i++) write_key(4'(i), xk[i]);
    endtask

    task automatic accept_block(input logic [127:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        if (n >= 200) tmo("accept");
        @(posedge clk); #1;
        acc_state = rnd_state;
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (lat >= 200) tmo("out_valid");
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_data"}, out_data, 128'(0));
        chk({tag, "_key_wr_err"}, 128'(key_wr_err), 128'(0));
        chk({tag, "_keys_ready"}, 128'(keys_ready), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_round_cnt"}, 128'(round_cnt), 128'(0));
        chk({tag, "_rnd_last"}, 128'(rnd_last), 128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, n;
        rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        build_tables();
        expand_key(FIPS_KEY);

        // model pins from FIPS-197 C.3
        chk("pin_key0", xk[0], FIPS_KEY[255:128]);
        chk("pin_key14", xk[14], FIPS_K14);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // partial key load blocks acceptance
        for (int i = 0; i < NR; i++) write_key(4'(i), xk[i]);
        in_data  = FIPS_CT;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("partial_keys_ready", 128'(keys_ready), 128'(0));
        chk("partial_in_ready", 128'(in_ready), 128'(0));
        write_key(4'(NR), xk[NR]);
        #1;
        chk("full_in_ready", 128'(in_ready), 128'(1));

        // FIPS vector, latency
        accept_block(FIPS_CT);
        chk("fips_round1_state", acc_state, FIPS_IS1);
        wait_out(lat);
        chk("fips_latency", 128'(lat), 128'(NR));
        chk("fips_plaintext", out_data, FIPS_PT);
        @(posedge clk); #1;
        chk("post_hs_in_ready", 128'(in_ready), 128'(1));
        #1;

        // backpressure then back-to-back block
        out_ready = 1'b0;
        accept_block(FIPS_CT);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_data", out_data, FIPS_PT);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        #1;
        accept_block({$urandom(), $urandom(), $urandom(), $urandom()});
        wait_out(lat);
        chk("b2b_latency", 128'(lat), 128'(NR));
        @(posedge clk); #2;

        // key write while busy is dropped
        accept_block(FIPS_CT);
        repeat (3) @(posedge clk);
        #2;
        key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
        chk("busy_wr_err_pulse", 128'(key_wr_err), 128'(1));
        #1 key_wr_en = 1'b0;
        @(posedge clk); #1;
        chk("busy_wr_err_clear", 128'(key_wr_err), 128'(0));
        #1;
        wait_out(lat);
        chk("busy_wr_plaintext", out_data, FIPS_PT);
        @(posedge clk); #2;
        accept_block(FIPS_CT);
        wait_out(lat);
        chk("slot3_kept_plaintext", out_data, FIPS_PT);
        @(posedge clk); #2;

        // out-of-range index in IDLE
        write_key(4'd15, {$urandom(), $urandom(), $urandom(), $urandom()});
        chk("idx15_err", 128'(key_wr_err), 128'(1));
        chk("idx15_keys_ready", 128'(keys_ready), 128'(1));

        // reset in the middle of round 7
        accept_block(FIPS_CT);
        n = 0;
        while (n < 50) begin
            @(posedge clk); #1;
            if (round_cnt == 4'd7) break;
            n++;
        end
        if (n >= 50) tmo("round7");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("midrst_keys_cleared", 128'(keys_ready), 128'(0));
        load_fips_keys();
        accept_block(FIPS_CT);
        wait_out(lat);
        chk("midrst_latency", 128'(lat), 128'(NR));
        chk("midrst_plaintext", out_data, FIPS_PT);
        @(posedge clk); #2;

        // randomized traffic with random keys
        for (int i = 0; i <= NR; i++)
            write_key(4'(i), {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #2;
            in_valid    = 1'($urandom_range(0, 1));
            in_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready   = ($urandom_range(0, 3) != 0);
            key_wr_en   = ($urandom_range(0, 15) == 0);
            key_wr_idx  = 4'($urandom_range(0, 15));
            key_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk); #2;
        in_valid = 1'b0; key_wr_en = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_idle", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
